// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one byte-wide memory between the ifetch and data ports.
// One access in flight; an access the memory never answers is aborted with err.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic                  err,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic                  mem_ready
);
    import mem_arb_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    state_e                state_q, state_d;
    logic                  port_q, port_d;
    logic                  we_q, we_d;
    logic                  last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
    logic                  ack0_q, ack0_d;
    logic                  ack1_q, ack1_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;

    logic                  grant_c;
    logic                  we_sel_c;
    logic [DATA_WIDTH-1:0] rd_result_c;

    // State register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            port_q        <= PORT_IFETCH;
            we_q          <= 1'b0;
            last_grant_q  <= PORT_DATA;
            cnt_q         <= '0;
            rdata0_q      <= '0;
            rdata1_q      <= '0;
            ack0_q        <= 1'b0;
            ack1_q        <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            port_q        <= port_d;
            we_q          <= we_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            rdata0_q      <= rdata0_d;
            rdata1_q      <= rdata1_d;
            ack0_q        <= ack0_d;
            ack1_q        <= ack1_d;
            err_q         <= err_d;
            busy_q        <= busy_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d       = state_q;
        port_d        = port_q;
        we_d          = we_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        ack0_d        = 1'b0;
        ack1_d        = 1'b0;
        err_d         = 1'b0;
        busy_d        = busy_q;
        mem_address_d = mem_address_q;
        mem_wdata_d   = mem_wdata_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        grant_c       = PORT_IFETCH;
        we_sel_c      = we0;
        rd_result_c   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    // Tie goes to whichever port was not served last
                    if (req0 && req1) begin
                        grant_c = ~last_grant_q;
                    end else begin
                        grant_c = req1 ? PORT_DATA : PORT_IFETCH;
                    end
                    we_sel_c      = (grant_c == PORT_DATA) ? we1 : we0;
                    port_d        = grant_c;
                    last_grant_d  = grant_c;
                    we_d          = we_sel_c;
                    mem_address_d = (grant_c == PORT_DATA) ? addr1 : addr0;
                    mem_wdata_d   = (grant_c == PORT_DATA) ? wdata1 : wdata0;
                    cnt_d         = '0;
                    mem_read_d    = ~we_sel_c;
                    mem_write_d   = we_sel_c;
                    busy_d        = 1'b1;
                    state_d       = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // mem_ready takes priority over a coinciding timeout
                if (mem_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
                    rd_result_c = mem_ready ? mem_rdata : '0;
                    if (!we_q) begin
                        if (port_q == PORT_DATA) begin
                            rdata1_d = rd_result_c;
                        end else begin
                            rdata0_d = rd_result_c;
                        end
                    end
                    ack0_d      = (port_q == PORT_IFETCH);
                    ack1_d      = (port_q == PORT_DATA);
                    err_d       = ~mem_ready;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d      = 1'b0;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    assign rdata0      = rdata0_q;
    assign rdata1      = rdata1_q;
    assign ack0        = ack0_q;
    assign ack1        = ack1_q;
    assign err         = err_q;
    assign busy        = busy_q;
    assign mem_address = mem_address_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single byte-wide memory between the CPU instruction-fetch port (port 0) and the data load/store port (port 1). Round-robin arbitration, one access in flight at a time. Drives the memory's read/write/ready handshake and aborts with an error if the memory never answers. Sits between the CPU core and the memory block.

Parameters:
ADDR_WIDTH, 8, address width of memory and both requesters
DATA_WIDTH, 8, data width
TIMEOUT, 15, max cycles in ACCESS without mem_ready before abort (>=1)

Ports:
clk  input  1  clock
reset  input  1  sync active-high reset
req0, req1  input  1 each  access request, held until matching ack
we0, we1  input  1 each  1 = write, 0 = read; stable while req high
addr0, addr1  input  ADDR_WIDTH each  access address
wdata0, wdata1  input  DATA_WIDTH each  write data
rdata0, rdata1  output  DATA_WIDTH each  registered read data, valid in ack cycle
ack0, ack1  output  1 each  one-cycle completion pulse
err  output  1  pulses with ack when the access timed out
busy  output  1  high in ACCESS and DONE
mem_address  output  ADDR_WIDTH  to memory
mem_wdata  output  DATA_WIDTH  to memory
mem_rdata  input  DATA_WIDTH  from memory
mem_read, mem_write  output  1 each  memory strobes
mem_ready  input  1  memory completion, read data valid same cycle

Behaviour:
- Clock clk; reset is synchronous, active-high. Reset: state IDLE, all outputs 0, last_grant=1, timeout counter 0.
- States: IDLE, ACCESS, DONE.
- IDLE: sample req0/req1. Neither -> stay. One -> grant it. Both -> grant port != last_grant (port 0 wins first tie after reset). On grant: latch port, we, addr, wdata; last_grant <= port; counter <= 0; -> ACCESS.
- ACCESS: mem_read = !we_l, mem_write = we_l, mem_address/mem_wdata from latched values, stable throughout. Counter +1 per cycle.
  - mem_ready=1 -> DONE; read: rdataN <= mem_rdata; write: rdataN unchanged.
  - else counter == TIMEOUT-1 -> DONE with err flag set; read: rdataN <= 0.
  - mem_ready wins if it coincides with timeout.
- DONE (1 cycle): strobes low; ackN=1 for granted port only; err=1 if flagged; -> IDLE.
- Latency: req seen in IDLE at cycle 0 -> strobe high cycles 1..D (D = memory delay) -> ack at cycle D+1 -> IDLE at D+2. Back-to-back throughput: one access per D+2 cycles.
- Requests sampled only in IDLE; req changes during ACCESS/DONE ignored. Dropping req mid-access does not cancel; ack still pulses.
- mem_ready in IDLE or DONE ignored.
- Strobes always drop for at least one cycle between accesses; mem_read and mem_write never high together.
- ack0 and ack1 never high together. Reset mid-operation: next edge IDLE, strobes low, no ack for aborted access.
- rdataN holds last value until next read completion on that port.

Decomposition:
- Package mem_arb_pkg: state encoding (IDLE/ACCESS/DONE), port index constants PORT_IFETCH=0, PORT_DATA=1.
- No sub-module; round-robin select is a few lines inline. Counter width = clog2(TIMEOUT)+1.

Test Plan:
- Single read: req0, addr0=0x10, memory delay 2 returns 0xA5 -> mem_read high 2 cycles, ack0 pulse cycle 3 with rdata0=0xA5, err=0.
- Single write: req1, we1=1, addr1=0x20, wdata1=0x3C -> mem_write high, mem_address=0x20, mem_wdata=0x3C until ready; ack1 pulse, later read of 0x20 returns 0x3C.
- Contention: req0 and req1 together, held -> grant order port0, port1, port0; ack0/ack1 alternate, strobe low one cycle between accesses.
- Timeout: mem_ready tied 0, read on port 1 -> strobe high 15 cycles, ack1+err pulse, rdata1=0x00, next access proceeds normally.
- Reset mid-access: assert reset during ACCESS -> next cycle strobes 0, busy 0, no ack; post-reset tie grants port 0.
- Requester drops req0 during ACCESS -> access completes, ack0 still pulses; no second access started.
